// File: rtl/poly_arith_pkg.sv
// Shared polynomial-arithmetic types and Montgomery constants (R = 2^16).
// The optional BASEMUL_CANON_EN macro is consumed by basemul_lane.
package poly_arith_pkg;
    typedef logic signed [15:0] coeff_t;

    localparam int KYBER_Q = 3329;
    localparam int R_W     = 16;

    // q^-1 mod 2^16 by Newton iteration; q odd gives 3 correct bits to start.
    function automatic logic [R_W-1:0] mont_qinv(input int q);
        logic [R_W-1:0] x;
        logic [R_W-1:0] q_lo;
        q_lo = q[R_W-1:0];
        x    = q_lo;
        for (int i = 0; i < 4; i++) begin
            x = x * (16'd2 - q_lo * x);
        end
        return x;
    endfunction

    localparam logic [R_W-1:0] QINV = mont_qinv(KYBER_Q);
endpackage

// File: rtl/basemul_lane.sv
// One lane of the base multiplier: S1 products, S2 zeta term and c1 sum,
// S3 final reductions, accumulate fold and (with BASEMUL_CANON_EN) canonicalisation.
module basemul_lane
    import poly_arith_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_ld1,
    input  logic        i_ld2,
    input  logic        i_ld3,
    input  logic        i_acc,
    input  logic [15:0] i_a0,
    input  logic [15:0] i_a1,
    input  logic [15:0] i_b0,
    input  logic [15:0] i_b1,
    input  logic [15:0] i_zeta,
    input  logic [15:0] i_d0,
    input  logic [15:0] i_d1,
    output logic [15:0] o_c0,
    output logic [15:0] o_c1
);
    logic signed [31:0] r_p00, r_p11, r_p01, r_p10;
    logic signed [31:0] r_sum0, r_sum1;
    logic [15:0]        r_zeta1;
    coeff_t             r_d0_1, r_d1_1, r_d0_2, r_d1_2;
    coeff_t             r_c0, r_c1;

    logic [15:0]        w_red11, w_red0, w_red1;
    logic signed [31:0] w_tw;

    function automatic coeff_t finish(input coeff_t r, input coeff_t d, input logic acc);
        logic signed [16:0] s;
        logic signed [16:0] q17;
        q17 = 17'(Q);
        s   = acc ? (17'(r) + 17'(d)) : 17'(r);
        if (s >= q17) begin
            s = s - q17;
        end else if (s <= -q17) begin
            s = s + q17;
        end
`ifdef BASEMUL_CANON_EN
        if (s < 0) begin
            s = s + q17;
        end
`endif
        return coeff_t'(s[15:0]);
    endfunction

    modular_reduce #(.Q(Q)) u_red11 (.i_a(r_p11),  .o_r(w_red11));
    modular_reduce #(.Q(Q)) u_red0  (.i_a(r_sum0), .o_r(w_red0));
    modular_reduce #(.Q(Q)) u_red1  (.i_a(r_sum1), .o_r(w_red1));

    // zeta is an unsigned ROM constant, so it is zero-extended before the signed multiply.
    assign w_tw = 32'($signed(w_red11)) * $signed({16'd0, r_zeta1});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p00   <= '0;
            r_p11   <= '0;
            r_p01   <= '0;
            r_p10   <= '0;
            r_zeta1 <= '0;
            r_d0_1  <= '0;
            r_d1_1  <= '0;
            r_sum0  <= '0;
            r_sum1  <= '0;
            r_d0_2  <= '0;
            r_d1_2  <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
        end else begin
            if (i_ld1) begin
                r_p00   <= 32'($signed(i_a0)) * 32'($signed(i_b0));
                r_p11   <= 32'($signed(i_a1)) * 32'($signed(i_b1));
                r_p01   <= 32'($signed(i_a0)) * 32'($signed(i_b1));
                r_p10   <= 32'($signed(i_a1)) * 32'($signed(i_b0));
                r_zeta1 <= i_zeta;
                r_d0_1  <= coeff_t'(i_d0);
                r_d1_1  <= coeff_t'(i_d1);
            end
            if (i_ld2) begin
                r_sum0 <= r_p00 + w_tw;
                r_sum1 <= r_p01 + r_p10;
                r_d0_2 <= r_d0_1;
                r_d1_2 <= r_d1_1;
            end
            if (i_ld3) begin
                r_c0 <= finish(coeff_t'(w_red0), r_d0_2, i_acc);
                r_c1 <= finish(coeff_t'(w_red1), r_d1_2, i_acc);
            end
        end
    end

    assign o_c0 = r_c0;
    assign o_c1 = r_c1;
endmodule

// File: rtl/modular_reduce.sv
// Combinational Montgomery reduction: returns a * 2^-16 mod Q, in (-Q, Q)
// for |a| < Q * 2^15.
module modular_reduce
    import poly_arith_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic [31:0] i_a,
    output logic [15:0] o_r
);
    localparam logic [R_W-1:0]  QINV_L = (Q == KYBER_Q) ? QINV : mont_qinv(Q);
    localparam logic signed [31:0] Q_W = 32'(Q);

    logic [R_W-1:0]     w_t_lo;
    coeff_t             w_t;
    logic signed [31:0] w_u;

    always_comb begin
        w_t_lo = i_a[R_W-1:0] * QINV_L;
        w_t    = coeff_t'(w_t_lo);
        // Low half of w_u is zero by construction, so the shift is exact.
        w_u    = $signed(i_a) - (32'(w_t) * Q_W);
        o_r    = 16'(w_u >>> R_W);
    end
endmodule

// File: rtl/basemul_pipe.sv
// Three-stage pipelined base multiplier over LANES coefficient pairs.
// Define BASEMUL_CANON_EN for canonical [0, Q-1] outputs.
module basemul_pipe
    import poly_arith_pkg::*;
#(
    parameter int LANES = 2,
    parameter int Q     = KYBER_Q
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [LANES*16-1:0] a0_i,
    input  logic [LANES*16-1:0] a1_i,
    input  logic [LANES*16-1:0] b0_i,
    input  logic [LANES*16-1:0] b1_i,
    input  logic [LANES*16-1:0] zeta_i,
    input  logic               acc_i,
    input  logic [LANES*16-1:0] d0_i,
    input  logic [LANES*16-1:0] d1_i,
    input  logic               last_i,
    output logic [LANES*16-1:0] c0_o,
    output logic [LANES*16-1:0] c1_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               last_o
);
    // Handshake: a beat moves across an interface on a rising edge where valid
    // and ready are both high; a valid holder keeps its data stable until then.
    // A stage advances when it is empty or the stage after it advances, so
    // bubbles collapse during a stall while valid beats hold in place.
    logic r_v1, r_v2, r_v3;
    logic r_acc1, r_acc2;
    logic r_last1, r_last2, r_last3;
    logic w_stall, w_en1, w_en2, w_en3, w_ld1, w_ld2, w_ld3;

    assign w_stall    = r_v3 & ~out_ready_i;
    assign in_ready_o = ~w_stall;
    assign w_en3      = ~r_v3 | out_ready_i;
    assign w_en2      = ~r_v2 | w_en3;
    assign w_en1      = ~r_v1 | w_en2;
    assign w_ld1      = in_valid_i & in_ready_o;
    assign w_ld2      = w_en2 & r_v1;
    assign w_ld3      = w_en3 & r_v2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_acc1  <= 1'b0;
            r_acc2  <= 1'b0;
            r_last1 <= 1'b0;
            r_last2 <= 1'b0;
            r_last3 <= 1'b0;
        end else begin
            if (w_en1) r_v1 <= w_ld1;
            if (w_ld1) begin
                r_acc1  <= acc_i;
                r_last1 <= last_i;
            end
            if (w_en2) r_v2 <= r_v1;
            if (w_ld2) begin
                r_acc2  <= r_acc1;
                r_last2 <= r_last1;
            end
            if (w_en3) begin
                r_v3    <= r_v2;
                r_last3 <= r_v2 & r_last2;
            end
        end
    end

    assign out_valid_o = r_v3;
    assign last_o      = r_last3;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        basemul_lane #(.Q(Q)) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .i_ld1  (w_ld1),
            .i_ld2  (w_ld2),
            .i_ld3  (w_ld3),
            .i_acc  (r_acc2),
            .i_a0   (a0_i[16*k +: 16]),
            .i_a1   (a1_i[16*k +: 16]),
            .i_b0   (b0_i[16*k +: 16]),
            .i_b1   (b1_i[16*k +: 16]),
            .i_zeta (zeta_i[16*k +: 16]),
            .i_d0   (d0_i[16*k +: 16]),
            .i_d1   (d1_i[16*k +: 16]),
            .o_c0   (c0_o[16*k +: 16]),
            .o_c1   (c1_o[16*k +: 16])
        );
    end
endmodule

// File: doc/basemul_pipe.md
BASEMUL_PIPE -- requirements
Module: basemul_pipe

Interface
REQ-001 Parameter LANES, default 2, number of independent coefficient pairs (a0,a1)x(b0,b1) processed per beat; legal 1..8.
REQ-002 Parameter Q, default 3329, modulus used by the folding and canonicalisation steps.
REQ-003 clk_i  in  1  sole clock; all state on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 in_valid_o/in_ready_o handshake: in_valid_i  in  1  beat present; in_ready_o  out  1  beat accepted when both high.
REQ-006 a0_i, a1_i, b0_i, b1_i  in  LANES*16 each  packed signed coefficients; lane k is bits [16k+15:16k].
REQ-007 zeta_i  in  LANES*16  per-lane zeta, zero-extended ROM constant.
REQ-008 acc_i  in  1  accumulate mode for this beat; d0_i, d1_i  in  LANES*16  signed addends, each in (-Q,Q), ignored when acc_i=0.
REQ-009 last_i  in  1  sideband end-of-polynomial flag, passed through aligned with its beat.
REQ-010 c0_o, c1_o  out  LANES*16  packed results; out_valid_o  out  1; out_ready_i  in  1; last_o  out  1.

Function
REQ-011 Per lane: c0 = a0*b0 + reduce(a1*b1)*zeta, c1 = a0*b1 + a1*b0, each Montgomery-reduced (R=2^16), result r in (-Q,Q).
REQ-012 Products 16x16 signed into 32-bit; sums accumulated at 32 bits before the final reduction (lazy reduction).
REQ-013 Accumulate (acc_i=1): s = r + d; if s >= Q then s-Q; if s <= -Q then s+Q; output in (-Q,Q). acc_i=0: output r.
REQ-014 Pipeline is exactly 3 stages: S1 products, S2 reduce(a1*b1)*zeta and c1 sum, S3 final reductions and accumulate; latency 3 cycles from acceptance to out_valid_o with no stall.
REQ-015 Throughput one beat per cycle while out_ready_i=1.
REQ-016 Stall: stall = out_valid_o & ~out_ready_i; whole pipeline holds; in_ready_o = ~stall (combinational).
REQ-017 Bubbles (invalid stages) advance during stall only if downstream stage is also invalid; no beat ever lost or duplicated.
REQ-018 Outputs, last_o and per-stage acc/d registers hold stable while out_valid_o=1 and out_ready_i=0.
REQ-019 All lanes share one valid/last/acc; lanes never diverge in timing.
REQ-020 in_valid_i=1 with in_ready_o=0: inputs not sampled; upstream must hold.

Reset
REQ-021 rst_i asserted at any time: all stage valids, out_valid_o, last_o clear to 0 immediately; c0_o, c1_o clear to 0; in_ready_o=1.
REQ-022 Reset mid-operation discards all in-flight beats; first beat after deassertion appears 3 cycles after acceptance.

Configuration
REQ-023 Macro BASEMUL_CANON_EN defined: an extra combinational step in S3 adds Q to negative results, outputs canonical [0,Q-1]; latency unchanged.
REQ-024 BASEMUL_CANON_EN undefined: outputs signed in (-Q,Q) per REQ-011/013.

Structure
REQ-025 coeff_t, Q constant, Montgomery constants (QINV, R width) live in poly_arith_pkg; no local redefinitions.
REQ-026 One sub-module basemul_lane: one lane's S1-S3 datapath registers, instantiating modular_reduce three times; basemul_pipe holds shared valid/last/acc control and a generate loop over LANES.

Verification
REQ-027 LANES=2, lane0 a0=256,b0=256, others 0, acc_i=0 -> 3 cycles later c0=1, c1=0 in lane0; lane1 all zero -> c0=c1=0.
REQ-028 lane0 a0=256,b0=256, acc_i=1, d0=3328, d1=7 -> c0=0 (fold 3329->0), c1=7.
REQ-029 lane0 a0=-256,b0=256, acc_i=0 -> c0=-1 without BASEMUL_CANON_EN, c0=3328 with it.
REQ-030 Stream 16 random beats (zeta=17 on all lanes) with out_ready_i held low cycles 5-8 -> outputs match golden model in order, no loss/duplication, outputs stable during stall, in_ready_o=0 while stalled, last_o on beat 16 only.
REQ-031 rst_i pulsed with 3 beats in flight -> out_valid_o=0 same cycle; no stale beat emerges; next beat after reset returns after exactly 3 cycles.
